// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers responses.
// Define FETCH_PERF_EN to add the fetch_count output (saturating pop counter).
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [5:0]         opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] prd_q, prd_d;
    logic [PW-1:0] pwr_q, pwr_d;

    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  fpc_mem  [DEPTH];
    logic [ADDR_W-1:0]  ipc_mem  [DEPTH];

    logic req_fire;
    logic rsp_ok;
    logic push;
    logic pop;
    logic [CW:0] credit_used;

    // Credits cover both in-flight requests and buffered entries, so a push never overflows.
    assign credit_used = {1'b0, out_q} + {1'b0, cnt_q};

    assign imem_req_valid = !rst && (state_q == RUN) && !redirect_valid
                            && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr = pc_q;

    assign instr_valid = (cnt_q != '0);
    assign instr       = instr_valid ? data_mem[rd_q] : '0;
    assign instr_pc    = instr_valid ? fpc_mem[rd_q] : '0;
    assign opcode      = instr[31:26];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_ok   = imem_rsp_valid && (out_q != '0);
    assign push     = rsp_ok && (state_q == RUN) && !redirect_valid;
    assign pop      = instr_valid && !stall;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        out_d   = out_q + CW'(req_fire) - CW'(rsp_ok);
        pwr_d   = pwr_q + PW'(req_fire);
        prd_d   = prd_q + PW'(rsp_ok);
        rd_d    = rd_q + PW'(pop);
        wr_d    = wr_q + PW'(push);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);

        if (req_fire) begin
            pc_d = pc_q + ADDR_W'(4);
        end

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
            state_d = (out_d != '0) ? FLUSH : RUN;
        end else if ((state_q == FLUSH) && (out_d == '0)) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            prd_q   <= '0;
            pwr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            prd_q   <= prd_d;
            pwr_q   <= pwr_d;
        end
    end

    // Storage needs no reset: every read is qualified by a valid count.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            ipc_mem[pwr_q] <= pc_q;
        end
        if (push) begin
            data_mem[wr_q] <= imem_rsp_data;
            fpc_mem[wr_q]  <= ipc_mem[prd_q];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (pop && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level fetch model.
// Memory, credit and flush behaviour are modelled with queues of requests.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(32),
        .INSTR_W(32),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .opcode(opcode)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
        bit          orphan;
    } mreq_t;

    int errors = 0;
    int checks = 0;

    mreq_t       mq[$];
    logic [31:0] fq[$];
    logic [31:0] acc_q[$];
    logic [31:0] exp_req_pc;
    logic [31:0] perf_cnt;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int n_acc, n_pop, n_drop;
    int first_req_cyc, first_val_cyc;
    bit have_pop;
    logic [31:0] first_pop;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5C3_0F1E) * 32'h9E37_79B1;
    endfunction

    function automatic void mark();
        n_acc = 0;
        n_pop = 0;
        n_drop = 0;
        acc_q.delete();
        have_pop = 1'b0;
        first_pop = '0;
        first_req_cyc = -1;
        first_val_cyc = -1;
    endfunction

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input bit redir, input logic [31:0] rpc,
                        input bit stl, input bit rdy);
        int inflight;
        int nstale;
        bit exp_rv;
        bit rsp;
        logic [31:0] w;
        mreq_t e;
        redirect_valid = redir;
        redirect_pc = rpc;
        stall = stl;
        imem_req_ready = rdy;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? mem_word(mq[0].addr) : $urandom;
        #1;
        inflight = 0;
        nstale = 0;
        foreach (mq[i]) begin
            if (!mq[i].orphan) inflight++;
            if (mq[i].stale) nstale++;
        end
        exp_rv = !redir && (nstale == 0) && (inflight + fq.size() < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, exp_req_pc);
        check("instr_valid", instr_valid, fq.size() > 0);
        if (fq.size() > 0) begin
            w = mem_word(fq[0]);
            check("instr_pc", instr_pc, fq[0]);
            check("instr", instr, w);
            check("opcode", opcode, w[31:26]);
        end
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, perf_cnt);
`endif
        if (exp_rv && first_req_cyc < 0) first_req_cyc = cyc;
        if (fq.size() > 0 && first_val_cyc < 0) first_val_cyc = cyc;

        if (fq.size() > 0 && !stl) begin
            if (!have_pop) begin
                have_pop = 1'b1;
                first_pop = fq[0];
            end
            void'(fq.pop_front());
            n_pop++;
            if (perf_cnt != 32'hFFFF_FFFF) perf_cnt++;
        end
        if (rsp) begin
            e = mq.pop_front();
            if (!e.orphan && !e.stale && !redir) fq.push_back(e.addr);
            else if (!e.orphan) n_drop++;
        end
        if (redir) fq.delete();
        if (exp_rv && rdy) begin
            e.addr = exp_req_pc;
            e.due = cyc + $urandom_range(lat_min, lat_max);
            e.stale = 1'b0;
            e.orphan = 1'b0;
            mq.push_back(e);
            acc_q.push_back(exp_req_pc);
            n_acc++;
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (redir) begin
            exp_req_pc = rpc;
            foreach (mq[i]) if (!mq[i].orphan) mq[i].stale = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle; pending memory responses become orphans.
    task automatic do_reset();
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        stall = 1'b0;
        #1;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_opcode", opcode, 0);
`ifdef FETCH_PERF_EN
        check("rst_fetch_count", fetch_count, 0);
`endif
        foreach (mq[i]) begin
            mq[i].orphan = 1'b1;
            mq[i].stale = 1'b0;
        end
        fq.delete();
        exp_req_pc = RESET_PC;
        perf_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 16 && mq.size() > 0; k++) step(1'b0, '0, 1'b0, 1'b0);
        if (mq.size() > 0) check("orphan_drain", mq.size(), 0);
    endtask

    initial begin
        logic [31:0] rp;
        int r;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        stall = 1'b0;
        exp_req_pc = RESET_PC;
        perf_cnt = '0;
        mark();
        @(posedge clk);
        #1;

        // Straight-line fetch with one-cycle memory
        do_reset();
        mark();
        lat_min = 1;
        lat_max = 1;
        repeat (12) step(1'b0, '0, 1'b0, 1'b1);
        check("first_latency", first_val_cyc - first_req_cyc, 2);
        check("seq_first_pop", first_pop, RESET_PC);
        check("seq_acc3", acc_q[3], RESET_PC + 32'd12);

        // Continuous stall fills the credit window
        do_reset();
        mark();
        repeat (10) step(1'b0, '0, 1'b1, 1'b1);
        check("stall_reqs", n_acc, DEPTH);
        check("stall_pops", n_pop, 0);
        repeat (10) step(1'b0, '0, 1'b0, 1'b1);
        check("release_pops", n_pop >= DEPTH, 1);
        check("release_first", first_pop, RESET_PC);

        // Redirect with three requests in flight
        do_reset();
        mark();
        lat_min = 5;
        lat_max = 5;
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        check("flush_inflight", n_acc, 3);
        step(1'b1, 32'h100, 1'b0, 1'b1);
        lat_min = 1;
        lat_max = 1;
        repeat (15) step(1'b0, '0, 1'b0, 1'b1);
        check("flush_dropped", n_drop, 3);
        check("flush_next_req", acc_q[3], 32'h100);
        check("flush_first_pc", first_pop, 32'h100);

        // Redirect with zero outstanding after a same-cycle response
        do_reset();
        mark();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("redir0_dropped", n_drop, 1);
        check("redir0_req", acc_q[acc_q.size()-1], 32'h200);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1);
        check("redir0_first_pc", first_pop, 32'h200);

        // Reset with two requests in flight
        do_reset();
        mark();
        lat_min = 4;
        lat_max = 4;
        repeat (2) step(1'b0, '0, 1'b0, 1'b1);
        check("midrst_inflight", n_acc, 2);
        do_reset();
        mark();
        lat_min = 1;
        lat_max = 1;
        repeat (6) step(1'b0, '0, 1'b0, 1'b1);
        check("midrst_restart", acc_q[0], RESET_PC);
        check("midrst_first_pc", first_pop, RESET_PC);

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        for (int k = 0; k < 10 && mq.size() > 0; k++) step(1'b0, '0, 1'b0, 1'b1);
        mark();
        repeat (8) step(1'b0, '0, 1'b0, 1'b1);
        check("wrap_n", acc_q.size() >= 3, 1);
        if (acc_q.size() >= 3) check("wrap_addr", acc_q[2], 32'h0);
        check("wrap_first_pc", first_pop, 32'hFFFF_FFF8);

        // Ten pops after reset
        do_reset();
        mark();
        for (int k = 0; k < 40 && n_pop < 10; k++) step(1'b0, '0, 1'b0, 1'b1);
        check("pops10", n_pop, 10);
`ifdef FETCH_PERF_EN
        check("perf_10", fetch_count, 32'd10);
`endif

        // Random traffic
        lat_min = 1;
        lat_max = 4;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset();
            end else begin
                rp = $urandom;
                rp[1:0] = 2'b00;
                step(r < 40, rp, $urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 70);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
